// File: rtl/seg_pkg.sv
// seg_pkg: shared scan states and display constants for the segment scanner
package seg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF = 4'hF;
  typedef enum logic [1:0] {BLANK, FETCH, LATCH, SHOW} state_t;
endpackage

// File: rtl/hex7seg.sv
// hex7seg: 4-bit value to active-high {g,f,e,d,c,b,a} hex digit pattern
module hex7seg (
  input  logic [3:0] nib,
  output logic [6:0] pat
);
  localparam logic [6:0] TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  assign pat = TBL[nib];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexes four display-memory bytes onto a 4-digit common-anode display
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       hex_mode,
  output logic [1:0] dis_addr,
  input  logic [7:0] dis_data,
  output logic [3:0] an,
  output logic [7:0] seg
);
  localparam int CW = $clog2(DIV);
  if (DIV < BLANK_CYC + 3 || BLANK_CYC < 1) begin : g_bad_params
    $error("seg_scan_driver: need DIV >= BLANK_CYC+3 and BLANK_CYC >= 1");
  end
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [$clog2(NUM_DIGITS)-1:0] digit;
  logic [7:0] byte_q, dec_byte, seg_pat, seg_d;
  logic [6:0] hex_pat;
  logic [3:0] an_d;
  logic hex_q, dec_hex, last_blank, last_show, lit;
  assign last_blank = cnt == CW'(BLANK_CYC - 1);
  assign last_show = cnt == CW'(DIV - 1);
  assign dis_addr = digit;
  // in LATCH the fresh memory byte is decoded; otherwise the held copy keeps seg steady
  assign dec_byte = state == LATCH ? dis_data : byte_q;
  assign dec_hex = state == LATCH ? hex_mode : hex_q;
  hex7seg u_hex7seg (.nib(dec_byte[3:0]), .pat(hex_pat));
  // next-state, counter and next registered output values
  always_comb begin
    state_n = !enable ? BLANK :
              state == BLANK ? (last_blank ? FETCH : BLANK) :
              state == FETCH ? LATCH :
              state == LATCH ? SHOW :
              last_show ? BLANK : SHOW;
    cnt_n = (!enable || (state == SHOW && last_show)) ? '0 : cnt + 1'b1;
    lit = enable && (state == LATCH || (state == SHOW && !last_show));
    seg_pat = dec_hex ? {~dec_byte[7], ~hex_pat} : ~dec_byte;
    an_d = lit ? ~(4'b0001 << digit) : AN_OFF;
    seg_d = lit ? seg_pat : SEG_OFF;
  end
  // scan position: state, slot counter and current digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLANK;
      cnt <= '0;
      digit <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      digit <= !enable ? '0 : (state == SHOW && last_show) ? digit + 1'b1 : digit;
    end
  end
  // registered display outputs and the per-slot latched byte/mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an <= AN_OFF;
      seg <= SEG_OFF;
      byte_q <= 8'h00;
      hex_q <= 1'b0;
    end else begin
      an <= an_d;
      seg <= seg_d;
      if (enable && state == LATCH) begin
        byte_q <= dis_data;
        hex_q <= hex_mode;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed and randomized checks against a slot-arithmetic reference model
module tb_seg_scan_driver;
  localparam int DIV = 8;
  localparam int BC = 2;
  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  logic clk = 0, rst_n = 0, enable = 0, hex_mode = 0, chk_on = 0;
  logic [1:0] dis_addr;
  logic [7:0] dis_data = 8'h00;
  logic [3:0] an;
  logic [7:0] seg;
  logic [7:0] mem [4];
  logic [7:0] lat_b = 8'h00;
  logic lat_h = 1'b0;
  int total = 0, bad = 0, t = 0;
  seg_scan_driver #(.DIV(DIV), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .hex_mode(hex_mode),
    .dis_addr(dis_addr), .dis_data(dis_data), .an(an), .seg(seg)
  );
  always #5 clk = ~clk;
  // display memory port B: one-cycle synchronous read
  always @(posedge clk) dis_data <= mem[dis_addr];
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at t=%0d time=%0t", tag, got, exp, t, $time);
    end
  endtask
  function automatic logic [7:0] pattern(input logic [7:0] b, input logic h);
    return h ? {~b[7], ~HEX[b[3:0]]} : ~b;
  endfunction
  // model: t is the cycle index since the scan (re)started; slot = t/DIV, position = t%DIV
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !enable) t = 0;
    else begin
      if (t % DIV == BC) lat_b = mem[(t / DIV) % 4];
      if (t % DIV == BC + 1) lat_h = hex_mode;
      t++;
    end
  end
  // every cycle, compare outputs against the model away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      check("an", {4'h0, an}, (t % DIV >= BC + 2) ? {4'h0, ~(4'b0001 << ((t / DIV) % 4))} : 8'h0F);
      check("seg", seg, (t % DIV >= BC + 2) ? pattern(lat_b, lat_h) : 8'hFF);
      check("addr", {6'h0, dis_addr}, 8'((t / DIV) % 4));
    end
  end
  task automatic go_to(input int n);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (t != n && k < 400);
    if (t != n) check("go_to_timeout", 8'(t), 8'(n));
  endtask
  initial begin
    logic [3:0] an_tab [5];
    logic [7:0] seg_tab [5];
    int k;
    an_tab = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'hC0};
    mem = '{8'h3F, 8'h06, 8'h5B, 8'h4F};
    repeat (3) @(negedge clk);
    enable = 1;
    check("rst_an", {4'h0, an}, 8'h0F);
    check("rst_seg", seg, 8'hFF);
    check("rst_addr", {6'h0, dis_addr}, 8'h00);
    rst_n = 1;
    chk_on = 1;
    go_to(3);
    check("pre_lit_an", {4'h0, an}, 8'h0F);
    for (int i = 0; i < 5; i++) begin
      go_to(4 + 8 * i);
      check("raw_an", {4'h0, an}, {4'h0, an_tab[i]});
      check("raw_seg", seg, seg_tab[i]);
    end
    go_to(39);
    check("hold_an", {4'h0, an}, 8'h0E);
    mem[2] = 8'h8A;
    hex_mode = 1;
    go_to(40);
    check("slot_blank_an", {4'h0, an}, 8'h0F);
    go_to(52);
    check("hex_an", {4'h0, an}, 8'h0B);
    check("hex_seg", seg, 8'h08);
    hex_mode = 0;
    go_to(76);
    check("mid_before", seg, 8'hF9);
    mem[1] = 8'h5B;
    go_to(79);
    check("mid_hold", seg, 8'hF9);
    go_to(108);
    check("mid_next", seg, 8'hA4);
    go_to(117);
    check("drop_lit", {4'h0, an}, 8'h0B);
    enable = 0;
    @(negedge clk);
    check("drop_an", {4'h0, an}, 8'h0F);
    check("drop_seg", seg, 8'hFF);
    repeat (2) @(negedge clk);
    enable = 1;
    repeat (3) @(negedge clk);
    check("reen_dark", {4'h0, an}, 8'h0F);
    @(negedge clk);
    check("reen_first", {4'h0, an}, 8'h0E);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) mem[$urandom_range(0, 3)] = 8'($urandom);
      if ($urandom_range(0, 29) == 0) hex_mode = ~hex_mode;
      if (enable && $urandom_range(0, 59) == 0) enable = 0;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1;
    end
    enable = 1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (t % DIV != BC + 3 && k < 100);
    check("arst_pre", {4'h0, an}, {4'h0, ~(4'b0001 << ((t / DIV) % 4))});
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("arst_an", {4'h0, an}, 8'h0F);
    check("arst_seg", seg, 8'hFF);
    check("arst_addr", {6'h0, dis_addr}, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (40) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
